// File: rtl/matrix_stream_accumulator_pkg.sv
// matrix_stream_accumulator_pkg: shared helpers for the tile stream accumulator
package matrix_stream_accumulator_pkg;

    function automatic int clamp_depth(input int d, input int max_d);
        return d == 0 ? 1 : (d > max_d ? max_d : d);
    endfunction

endpackage

// File: rtl/matrix_stream_accumulator_if.sv
// matrix_stream_accumulator_if: config, input tile stream and output tile stream bundle
interface matrix_stream_accumulator_if #(
    parameter int N         = 4,
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 34,
    parameter int DEPTH_W   = 3
);
    logic [DEPTH_W-1:0]             cfg_depth;
    logic                           clear;
    logic [N-1:0][IN_WIDTH-1:0]     in_data;
    logic                           in_valid;
    logic                           in_ready;
    logic [N-1:0][OUT_WIDTH-1:0]    out_data;
    logic                           out_valid;
    logic                           out_ready;

    modport master (
        output cfg_depth, clear, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  cfg_depth, clear, in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/matrix_stream_accumulator_lane.sv
// matrix_accumulator_lane: one tile element, running sum plus held output value
module matrix_accumulator_lane
    import matrix_stream_accumulator_pkg::*;
#(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 34,
    parameter bit SIGNED    = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 acc_en,
    input  logic                 last,
    input  logic                 clear,
    input  logic                 out_load,
    input  logic [IN_WIDTH-1:0]  in_data,
    output logic [OUT_WIDTH-1:0] out_data
);
    logic [OUT_WIDTH-1:0] acc;
    logic [OUT_WIDTH-1:0] sum;

    // extra top bit carries the sign (or a zero) so the size cast extends correctly
    function automatic logic [OUT_WIDTH-1:0] ext(input logic [IN_WIDTH-1:0] d);
        logic signed [IN_WIDTH:0] t;
        t = {SIGNED && d[IN_WIDTH-1], d};
        return OUT_WIDTH'(t);
    endfunction

    assign sum = acc + ext(in_data);

    always_ff @(posedge clk) begin
        if (rst || clear || last)
            acc <= '0;
        else if (acc_en)
            acc <= sum;
    end

    always_ff @(posedge clk) begin
        if (rst)
            out_data <= '0;
        else if (out_load)
            out_data <= sum;
    end
endmodule

// File: rtl/matrix_stream_accumulator.sv
// matrix_stream_accumulator: element-wise sum of groups of tiles with a one-tile output buffer
module matrix_stream_accumulator
    import matrix_stream_accumulator_pkg::*;
#(
    parameter int MAX_DEPTH = 4,
    parameter int IN_WIDTH  = 32,
    parameter int DIM0      = 2,
    parameter int DIM1      = 2,
    parameter bit SIGNED    = 0
) (
    input logic                          clk,
    input logic                          rst,
    matrix_stream_accumulator_if.slave   bus
);
    localparam int N         = DIM0 * DIM1;
    localparam int OUT_WIDTH = IN_WIDTH + $clog2(MAX_DEPTH);
    localparam int DEPTH_W   = $clog2(MAX_DEPTH + 1);

    logic [DEPTH_W-1:0] cnt;
    logic [DEPTH_W-1:0] depth;
    logic [DEPTH_W-1:0] cfg_eff;
    logic [DEPTH_W-1:0] cur_depth;
    logic               is_last;
    logic               accept;
    logic               out_valid;

    assign cfg_eff   = DEPTH_W'(clamp_depth(int'(bus.cfg_depth), MAX_DEPTH));
    assign cur_depth = cnt == '0 ? cfg_eff : depth;
    assign is_last   = cnt == cur_depth - DEPTH_W'(1);
    // only a closing beat needs the output buffer, so only it can be stalled
    assign bus.in_ready  = !rst && !bus.clear && !(is_last && out_valid && !bus.out_ready);
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = out_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            depth     <= DEPTH_W'(1);
            out_valid <= 1'b0;
        end else begin
            if (bus.clear)
                cnt <= '0;
            else if (accept)
                cnt <= is_last ? '0 : cnt + DEPTH_W'(1);
            if (accept && cnt == '0)
                depth <= cfg_eff;
            if (accept && is_last)
                out_valid <= 1'b1;
            else if (bus.out_ready)
                out_valid <= 1'b0;
        end
    end

    for (genvar k = 0; k < N; k++) begin : g_lane
        matrix_accumulator_lane #(
            .IN_WIDTH  (IN_WIDTH),
            .OUT_WIDTH (OUT_WIDTH),
            .SIGNED    (SIGNED)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .acc_en   (accept),
            .last     (accept && is_last),
            .clear    (bus.clear),
            .out_load (accept && is_last),
            .in_data  (bus.in_data[k]),
            .out_data (bus.out_data[k])
        );
    end
endmodule

// File: tb/tb_matrix_stream_accumulator.sv
// tb_matrix_stream_accumulator: directed and stress checks with a queue-based scoreboard
module tb_matrix_stream_accumulator;
    typedef logic [3:0][31:0] tin_t;
    typedef logic [3:0][33:0] tout_t;

    logic clk = 0;
    logic rst = 1;
    always #5 clk = ~clk;

    matrix_stream_accumulator_if #(.N(4), .IN_WIDTH(32), .OUT_WIDTH(34), .DEPTH_W(3)) bus ();
    matrix_stream_accumulator_if #(.N(4), .IN_WIDTH(8),  .OUT_WIDTH(10), .DEPTH_W(3)) sbus ();

    matrix_stream_accumulator u_dut (.clk(clk), .rst(rst), .bus(bus));
    matrix_stream_accumulator #(.IN_WIDTH(8), .SIGNED(1)) s_dut (.clk(clk), .rst(rst), .bus(sbus));

    int    checks = 0;
    int    errors = 0;
    tout_t q[$];
    tout_t mon_e;
    bit    stress_on = 0;
    int    m_cnt, m_dep;
    tout_t m_acc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic tin_t fill(input int b);
        tin_t r;
        for (int k = 0; k < 4; k++) r[k] = 32'(b + k);
        return r;
    endfunction

    // tile of n beats built by fill(): element k = sum of bases + n*k
    function automatic tout_t exp_t(input int s, input int n);
        tout_t r;
        for (int k = 0; k < 4; k++) r[k] = 34'(s + n * k);
        return r;
    endfunction

    // caller is at a negedge; returns at the negedge following acceptance
    task automatic send(input tin_t d, input int dep);
        int n = 0;
        bus.in_data   = d;
        bus.cfg_depth = 3'(dep);
        bus.in_valid  = 1;
        #1;
        while (!bus.in_ready) begin
            if (++n > 100) begin
                checks++;
                errors++;
                $display("FAIL send_timeout actual=stalled required=accepted");
                bus.in_valid = 0;
                return;
            end
            @(negedge clk);
            #1;
        end
        @(negedge clk);
        bus.in_valid = 0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (q.size() != 0) begin
            if (++n > 100) begin
                checks++;
                errors++;
                $display("FAIL drain actual=%0d_pending required=0", q.size());
                q.delete();
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic model(input tin_t d, input int cfg);
        if (m_cnt == 0) m_dep = cfg == 0 ? 1 : (cfg > 4 ? 4 : cfg);
        for (int k = 0; k < 4; k++) m_acc[k] += 34'(d[k]);
        m_cnt++;
        if (m_cnt == m_dep) begin
            q.push_back(m_acc);
            m_acc = '0;
            m_cnt = 0;
        end
    endtask

    initial forever begin
        @(negedge clk);
        #1;
        if (bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_tile actual=%0h required=none", bus.out_data);
            end else begin
                mon_e = q.pop_front();
                for (int k = 0; k < 4; k++) chk($sformatf("tile_el%0d", k), 64'(bus.out_data[k]), 64'(mon_e[k]));
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (stress_on) bus.out_ready = 1'($urandom_range(0, 1));
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        bus.in_valid = 0; bus.clear = 0; bus.out_ready = 0; bus.cfg_depth = 0; bus.in_data = '0;
        sbus.in_valid = 0; sbus.clear = 0; sbus.out_ready = 0; sbus.cfg_depth = 0; sbus.in_data = '0;
        repeat (3) @(negedge clk);
        chk("reset_out_valid", 64'(bus.out_valid), 0);
        chk("reset_out_data", 64'(bus.out_data[3]), 0);
        chk("reset_in_ready", 64'(bus.in_ready), 0);
        rst = 0;

        // signed: four beats of -128 -> -512 in 10 bits
        sbus.in_data = {4{8'h80}}; sbus.cfg_depth = 4; sbus.out_ready = 1; sbus.in_valid = 1;
        repeat (4) @(negedge clk);
        sbus.in_valid = 0;
        chk("signed_valid", 64'(sbus.out_valid), 1);
        for (int k = 0; k < 4; k++) chk($sformatf("signed_el%0d", k), 64'(sbus.out_data[k]), 64'h200);

        // basic depth-4 tile and one-cycle latency
        bus.out_ready = 1;
        q.push_back({4{34'd4}});
        repeat (3) send({4{32'd1}}, 4);
        chk("latency_before", 64'(bus.out_valid), 0);
        send({4{32'd1}}, 4);
        #1 chk("latency_after", 64'(bus.out_valid), 1);
        @(negedge clk);
        chk("valid_drop", 64'(bus.out_valid), 0);

        // back-pressure: tile 1 pending, tile 2 closing beat stalls
        bus.out_ready = 0;
        q.push_back(exp_t(30, 2)); q.push_back(exp_t(70, 2)); q.push_back(exp_t(110, 2));
        send(fill(10), 2); send(fill(20), 2); send(fill(30), 2);
        bus.in_data = fill(40); bus.cfg_depth = 2; bus.in_valid = 1;
        #1 chk("stall_in_ready", 64'(bus.in_ready), 0);
        @(negedge clk);
        bus.out_ready = 1;
        send(fill(40), 2); send(fill(50), 2); send(fill(60), 2);
        wait_idle();

        // depth 0 -> 1, depth 7 -> 4, mid-tile cfg change ignored
        for (int b = 5; b < 8; b++) q.push_back(exp_t(b, 1));
        for (int b = 5; b < 8; b++) send(fill(b), 0);
        q.push_back(exp_t(10, 4));
        for (int b = 1; b < 5; b++) send(fill(b), 7);
        q.push_back(exp_t(300, 2));
        send(fill(100), 2); send(fill(200), 4);
        q.push_back(exp_t(3, 3));
        repeat (3) send(fill(1), 3);
        wait_idle();

        // clear discards the partial tile but keeps the pending one
        bus.out_ready = 0;
        q.push_back(exp_t(9, 1));
        send(fill(9), 1); send(fill(1000), 4); send(fill(2000), 4);
        bus.clear = 1; bus.in_data = fill(3000); bus.in_valid = 1;
        #1 chk("clear_in_ready", 64'(bus.in_ready), 0);
        @(negedge clk);
        bus.clear = 0; bus.in_valid = 0;
        chk("clear_pending", 64'(bus.out_valid), 1);
        q.push_back(exp_t(50, 4));
        bus.out_ready = 1;
        for (int b = 11; b < 15; b++) send(fill(b), 4);
        wait_idle();

        // reset drops both the pending and the partial tile
        bus.out_ready = 0;
        send(fill(7), 1); send(fill(8), 4);
        chk("pre_rst_valid", 64'(bus.out_valid), 1);
        rst = 1;
        @(negedge clk);
        chk("rst_out_valid", 64'(bus.out_valid), 0);
        chk("rst_out_data", 64'(bus.out_data[1]), 0);
        rst = 0;
        bus.out_ready = 1;
        q.push_back(exp_t(10, 4));
        for (int b = 1; b < 5; b++) send(fill(b), 4);
        wait_idle();

        // random valid/ready stress against the reference model
        m_cnt = 0; m_dep = 1; m_acc = '0;
        stress_on = 1;
        for (int i = 0; i < 300; i++) begin
            tin_t d;
            int c;
            for (int k = 0; k < 4; k++) d[k] = $urandom();
            c = $urandom_range(0, 7);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            send(d, c);
            model(d, c);
        end
        stress_on = 0;
        bus.out_ready = 1;
        wait_idle();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
